// File: rtl/lab2_proc_imm_encoder.sv
// Streaming immediate encoder: packs a typed immediate into a base instruction word and
// queues the result (plus range/alignment/type error flags) in a 2-entry val/rdy FIFO.
module lab2_proc_imm_encoder (
  input  logic        clk,
  input  logic        reset,

  input  logic        in_val,
  output logic        in_rdy,
  input  logic [2:0]  in_imm_type,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_inst,

  output logic        out_val,
  input  logic        out_rdy,
  output logic [31:0] out_inst,
  output logic [2:0]  out_err,

  output logic [15:0] err_count
);

  typedef enum logic [2:0] {
    ImmI = 3'd0,
    ImmS = 3'd1,
    ImmB = 3'd2,
    ImmU = 3'd3,
    ImmJ = 3'd4
  } imm_type_e;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [2:0]  err;
  } entry_t;

  localparam logic [2:0] ErrRange = 3'b001;
  localparam logic [2:0] ErrAlign = 3'b010;
  localparam logic [2:0] ErrType  = 3'b100;

  // ---------------------------------------------------------------------------
  // Combinational encoder
  // ---------------------------------------------------------------------------

  // An immediate fits an N-bit signed field iff all bits from N-1 upward agree.
  logic fits_12;
  logic fits_13;
  logic fits_21;

  assign fits_12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits_13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits_21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  logic [31:0] enc_inst;
  logic [2:0]  enc_err;

  always_comb begin
    enc_inst = in_inst;
    enc_err  = '0;
    case (imm_type_e'(in_imm_type))
      ImmI: begin
        enc_inst[31:20] = in_imm[11:0];
        if (!fits_12) enc_err = enc_err | ErrRange;
      end
      ImmS: begin
        enc_inst[31:25] = in_imm[11:5];
        enc_inst[11:7]  = in_imm[4:0];
        if (!fits_12) enc_err = enc_err | ErrRange;
      end
      ImmB: begin
        enc_inst[31]    = in_imm[12];
        enc_inst[30:25] = in_imm[10:5];
        enc_inst[11:8]  = in_imm[4:1];
        enc_inst[7]     = in_imm[11];
        if (!fits_13)  enc_err = enc_err | ErrRange;
        if (in_imm[0]) enc_err = enc_err | ErrAlign;
      end
      ImmU: begin
        enc_inst[31:12] = in_imm[31:12];
        if (|in_imm[11:0]) enc_err = enc_err | ErrAlign;
      end
      ImmJ: begin
        enc_inst[31]    = in_imm[20];
        enc_inst[30:21] = in_imm[10:1];
        enc_inst[20]    = in_imm[11];
        enc_inst[19:12] = in_imm[19:12];
        if (!fits_21)  enc_err = enc_err | ErrRange;
        if (in_imm[0]) enc_err = enc_err | ErrAlign;
      end
      default: begin
        enc_inst = in_inst;
        enc_err  = ErrType;
      end
    endcase
  end

  entry_t enc_entry;
  assign enc_entry = '{inst: enc_inst, err: enc_err};

  // ---------------------------------------------------------------------------
  // 2-entry output queue; slot0 is always the head
  // ---------------------------------------------------------------------------

  occ_e   occ_q,   occ_d;
  entry_t slot0_q, slot0_d;
  entry_t slot1_q, slot1_d;
  logic   accept;
  logic   dequeue;

  // Ready comes only from registered occupancy, so no out_rdy -> in_rdy path.
  assign in_rdy  = (occ_q != StFull);
  assign out_val = (occ_q != StEmpty);
  assign accept  = in_val & in_rdy;
  assign dequeue = out_val & out_rdy;

  always_comb begin
    occ_d   = occ_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case (occ_q)
      StEmpty: begin
        if (accept) begin
          slot0_d = enc_entry;
          occ_d   = StOne;
        end
      end
      StOne: begin
        if (accept && dequeue) begin
          slot0_d = enc_entry;
        end else if (accept) begin
          slot1_d = enc_entry;
          occ_d   = StFull;
        end else if (dequeue) begin
          slot0_d = '0;
          occ_d   = StEmpty;
        end
      end
      StFull: begin
        if (dequeue) begin
          slot0_d = slot1_q;
          slot1_d = '0;
          occ_d   = StOne;
        end
      end
      default: begin
        occ_d   = StEmpty;
        slot0_d = '0;
        slot1_d = '0;
      end
    endcase
  end

  assign out_inst = out_val ? slot0_q.inst : '0;
  assign out_err  = out_val ? slot0_q.err  : '0;

  // ---------------------------------------------------------------------------
  // Saturating error counter
  // ---------------------------------------------------------------------------

  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (accept && (enc_err != 3'b000) && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  assign err_count = err_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q       <= StEmpty;
      slot0_q     <= '0;
      slot1_q     <= '0;
      err_count_q <= '0;
    end else begin
      occ_q       <= occ_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      err_count_q <= err_count_d;
    end
  end

endmodule
